pythag_leg_solver: RTL and testbench



---
 rtl/pythag_pkg.sv | 21 ++
 rtl/isqrt_step.sv | 36 +++
 rtl/pythag_leg_solver.sv | 151 +++++++++++++++
 tb/tb_pythag_leg_solver.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/pythag_pkg.sv
// ---------------------------------------------------------------------------
// pythag_pkg
// Shared definitions for the Pythagorean datapath blocks (hypotenuse unit
// and leg solver).
//   - pythag_state_t : control FSM states used by the iterative engines
//   - PYTH_WIDTH     : default operand width for C, A, B
//   - PYTH_CNT_W     : iteration counter width for the default width
// ---------------------------------------------------------------------------
package pythag_pkg;

    localparam int PYTH_WIDTH = 8;
    localparam int PYTH_CNT_W = $clog2(PYTH_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        ROOT = 2'd2,
        FIN  = 2'd3
    } pythag_state_t;

endpackage

// File: rtl/isqrt_step.sv
// ---------------------------------------------------------------------------
// isqrt_step
// One purely combinational step of a restoring digit-by-digit square root.
// Shared by the hypotenuse and leg-solver datapaths.
//   i_rem   [WIDTH+1:0] : partial remainder from the previous step
//   i_root  [WIDTH-1:0] : partial root from the previous step
//   i_bits  [1:0]       : next two radicand bits (MSB pair first)
//   o_rem   [WIDTH+1:0] : updated remainder
//   o_root  [WIDTH-1:0] : updated root (one new bit shifted in at the LSB)
// ---------------------------------------------------------------------------
module isqrt_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH+1:0] i_rem,
    input  logic [WIDTH-1:0] i_root,
    input  logic [1:0]       i_bits,
    output logic [WIDTH+1:0] o_rem,
    output logic [WIDTH-1:0] o_root
);

    logic [WIDTH+3:0] w_shift;
    logic [WIDTH+3:0] w_trial;
    logic             w_ge;

    // The remainder never exceeds 2*root, so the two bits shifted off the top
    // are always zero; keeping the full-width view costs nothing and keeps
    // the compare exact.
    always_comb begin
        w_shift = {i_rem, i_bits};
        w_trial = {2'b00, i_root, 2'b01};
        w_ge    = (w_shift >= w_trial);
        o_rem   = w_ge ? (WIDTH+2)'(w_shift - w_trial) : w_shift[WIDTH+1:0];
        o_root  = {i_root[WIDTH-2:0], w_ge};
    end

endmodule

// File: rtl/pythag_leg_solver.sv
// ---------------------------------------------------------------------------
// pythag_leg_solver
// Computes the missing leg B = floor(sqrt(C*C - A*A)) of a right triangle
// with an iterative restoring square root, one result bit per clock.
//   clk    : system clock, rising edge
//   rst    : synchronous active-high reset
//   start  : request pulse, only looked at while idle
//   c_in   : hypotenuse C (unsigned, WIDTH bits)
//   a_in   : known leg A (unsigned, WIDTH bits)
//   busy   : high while a request is being worked on
//   done   : one-cycle pulse when b_out/err are updated
//   b_out  : computed leg B, held until the next done
//   err    : set when A > C, held until the next done
// ---------------------------------------------------------------------------
module pythag_leg_solver
    import pythag_pkg::*;
#(
    parameter int WIDTH = PYTH_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] c_in,
    input  logic [WIDTH-1:0] a_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] b_out,
    output logic             err
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam int RAD_W = 2 * WIDTH;

    pythag_state_t r_state;
    pythag_state_t w_next;

    logic [WIDTH-1:0] r_c;
    logic [WIDTH-1:0] r_a;
    logic [RAD_W-1:0] r_rad;
    logic [WIDTH+1:0] r_rem;
    logic [WIDTH-1:0] r_root;
    logic [CNT_W-1:0] r_cnt;
    logic             r_err_pend;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_b;
    logic             r_err;

    logic             w_a_gt_c;
    logic [RAD_W-1:0] w_csq;
    logic [RAD_W-1:0] w_asq;
    logic [WIDTH+1:0] w_rem_nxt;
    logic [WIDTH-1:0] w_root_nxt;
    logic             w_last;

    // Squares and the error test work on the operands latched at accept,
    // so later changes on c_in/a_in cannot disturb a running computation.
    always_comb begin
        w_a_gt_c = (r_a > r_c);
        w_csq    = RAD_W'(r_c) * RAD_W'(r_c);
        w_asq    = RAD_W'(r_a) * RAD_W'(r_a);
        w_last   = (r_cnt == CNT_W'(WIDTH - 1));
    end

    isqrt_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_rem  (r_rem),
        .i_root (r_root),
        .i_bits (r_rad[RAD_W-1:RAD_W-2]),
        .o_rem  (w_rem_nxt),
        .o_root (w_root_nxt)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic: the error case skips the root loop entirely, and
    // the loop leaves after the last of WIDTH steps.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (start) w_next = LOAD;
            LOAD: w_next = w_a_gt_c ? FIN : ROOT;
            ROOT: if (w_last) w_next = FIN;
            FIN:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Datapath and output registers. done is a single-cycle pulse, so it
    // defaults low every cycle; b_out and err only move in FIN.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_c        <= '0;
            r_a        <= '0;
            r_rad      <= '0;
            r_rem      <= '0;
            r_root     <= '0;
            r_cnt      <= '0;
            r_err_pend <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_b        <= '0;
            r_err      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_c    <= c_in;
                        r_a    <= a_in;
                        r_busy <= 1'b1;
                    end
                end
                LOAD: begin
                    r_err_pend <= w_a_gt_c;
                    r_rad      <= w_a_gt_c ? '0 : (w_csq - w_asq);
                    r_rem      <= '0;
                    r_root     <= '0;
                    r_cnt      <= '0;
                end
                ROOT: begin
                    r_rem  <= w_rem_nxt;
                    r_root <= w_root_nxt;
                    r_rad  <= r_rad << 2;
                    r_cnt  <= r_cnt + CNT_W'(1);
                end
                FIN: begin
                    r_b    <= r_err_pend ? '0 : r_root;
                    r_err  <= r_err_pend;
                    r_done <= 1'b1;
                    r_busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign busy  = r_busy;
    assign done  = r_done;
    assign b_out = r_b;
    assign err   = r_err;

endmodule

// File: tb/tb_pythag_leg_solver.sv
// ---------------------------------------------------------------------------
// tb_pythag_leg_solver
// Directed bench for pythag_leg_solver with hand-computed expected legs.
// ---------------------------------------------------------------------------
module tb_pythag_leg_solver;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] c_in;
    logic [7:0] a_in;
    logic       busy;
    logic       done;
    logic [7:0] b_out;
    logic       err;

    int vectors;
    int miscompares;

    pythag_leg_solver #(
        .WIDTH (8)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .c_in  (c_in),
        .a_in  (a_in),
        .busy  (busy),
        .done  (done),
        .b_out (b_out),
        .err   (err)
    );

    // 10 time-unit clock; inputs change and outputs are sampled on the
    // falling edge, well away from the rising edge the design uses.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts the vector and flags any difference.
    task automatic checkOutput(input string tag, input int observed, input int expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Issues one request, scrambles the inputs right after the accept edge,
    // then waits (bounded) for done and checks latency, result and pulse width.
    task automatic applyStimulus(input string tag, input logic [7:0] c, input logic [7:0] a,
                                 input int expB, input int expErr, input int expLat);
        int lat;
        lat = 99;
        c_in  = c;
        a_in  = a;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        c_in  = ~c;
        a_in  = 8'd1;
        checkOutput({tag, "_busy"}, busy, 1);
        for (int n = 1; n <= 15; n++) begin
            @(negedge clk);
            if (done) begin
                lat = n;
                break;
            end
        end
        checkOutput({tag, "_lat"}, lat, expLat);
        checkOutput({tag, "_b"}, b_out, expB);
        checkOutput({tag, "_err"}, err, expErr);
        checkOutput({tag, "_busyoff"}, busy, 0);
        @(negedge clk);
        checkOutput({tag, "_pulse"}, done, 0);
    endtask

    initial begin
        int gap;
        int pulses;
        vectors     = 0;
        miscompares = 0;
        rst   = 1'b1;
        start = 1'b0;
        c_in  = '0;
        a_in  = '0;

        // Reset held for two cycles, then released.
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_b", b_out, 0);
        checkOutput("rst_err", err, 0);

        // Perfect squares, extremes and truncating cases.
        applyStimulus("c5a3", 8'd5, 8'd3, 4, 0, 10);
        applyStimulus("c13a5", 8'd13, 8'd5, 12, 0, 10);
        applyStimulus("c255a0", 8'd255, 8'd0, 255, 0, 10);
        applyStimulus("c10a10", 8'd10, 8'd10, 0, 0, 10);
        applyStimulus("c10a7", 8'd10, 8'd7, 7, 0, 10);
        applyStimulus("c200a199", 8'd200, 8'd199, 19, 0, 10);

        // A > C reports an error quickly; the next good request clears it.
        applyStimulus("c3a4", 8'd3, 8'd4, 0, 1, 2);
        applyStimulus("clr_err", 8'd13, 8'd5, 12, 0, 10);

        // start held high: back-to-back requests, inputs changed mid-run.
        c_in  = 8'd5;
        a_in  = 8'd3;
        start = 1'b1;
        @(negedge clk);
        c_in = 8'd13;
        a_in = 8'd5;
        gap  = 0;
        for (int n = 1; n <= 15; n++) begin
            @(negedge clk);
            if (done) begin
                gap = n;
                break;
            end
        end
        checkOutput("hold_lat1", gap, 10);
        checkOutput("hold_b1", b_out, 4);
        gap = 0;
        for (int n = 1; n <= 15; n++) begin
            @(negedge clk);
            if (done) begin
                gap = n;
                break;
            end
        end
        start = 1'b0;
        checkOutput("hold_gap", gap, 11);
        checkOutput("hold_b2", b_out, 12);
        repeat (14) @(negedge clk);
        checkOutput("hold_idle", busy, 0);

        // Reset during ROOT aborts: outputs clear and no done follows.
        c_in  = 8'd255;
        a_in  = 8'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_b", b_out, 0);
        checkOutput("abort_err", err, 0);
        pulses = 0;
        for (int n = 0; n < 14; n++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        checkOutput("abort_nodone", pulses, 0);

        // Engine still usable after the abort.
        applyStimulus("post_abort", 8'd10, 8'd6, 8, 0, 10);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
